led_sequencer: RTL

Moore-style controller that sequences the 4-bit LED pattern index and its 16-entry, 8-bit LED ROM. It gives the LED datapath a run/pause/single-step front end with a programmable step period, direction control and loop/one-shot modes. It sits between board-level pushbutton/control strobes and the LED outputs, and replaces free-running index stepping.

---
 rtl/led_seq_pkg.sv | 9 +
 rtl/led_sequencer_if.sv | 15 +
 rtl/led_sequencer_prescaler.sv | 17 +
 rtl/led_sequencer.sv | 76 +++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared widths, FSM state type and LED pattern ROM for led_sequencer.
package led_seq_pkg;
  localparam int IDX_W = 4;
  localparam int LED_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  function automatic logic [LED_W-1:0] led_rom(input logic [IDX_W-1:0] idx);
    return idx == '0 ? '0 : idx <= 4'd8 ? 8'h01 << (idx - 4'd1) : 8'h80 >> (idx - 4'd8);
  endfunction
endpackage

// File: rtl/led_sequencer_if.sv
// led_sequencer_if: control strobes in, LED index/pattern and status out.
interface led_sequencer_if;
  import led_seq_pkg::*;
  logic             i_start;
  logic             i_stop;
  logic             i_step;
  logic             i_dir;
  logic             i_loop;
  logic [IDX_W-1:0] o_led_index;
  logic [LED_W-1:0] o_led;
  logic             o_busy;
  logic             o_done;
  modport master (output i_start, i_stop, i_step, i_dir, i_loop, input o_led_index, o_led, o_busy, o_done);
  modport slave (input i_start, i_stop, i_step, i_dir, i_loop, output o_led_index, o_led, o_busy, o_done);
endinterface

// File: rtl/led_sequencer_prescaler.sv
// led_prescaler: step-period counter; holds its value while disabled so a pause keeps the phase.
module led_prescaler #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] TOP = W'(CLK_DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == TOP;
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: run/pause/step FSM driving the LED pattern index and ROM lookup.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int LAST_IDX = 15
) (
  input  logic            i_clk,
  input  logic            i_rst,
  led_sequencer_if.slave  bus
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             pre_en, pre_clr, tick, adv, wrap;
  led_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (
    .clk (i_clk),
    .rst (i_rst),
    .en  (pre_en),
    .clr (pre_clr),
    .tick(tick)
  );
  assign wrap = bus.i_dir ? idx_q == '0 : idx_q == LAST;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    pre_en  = 1'b0;
    pre_clr = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        pre_clr = 1'b1;
        if (!bus.i_stop && bus.i_start) begin
          state_d = RUN;
          idx_d   = bus.i_dir ? LAST : '0;
        end
      end
      RUN: begin
        state_d = bus.i_stop ? PAUSE : RUN;
        pre_en  = !bus.i_stop;
        adv     = !bus.i_stop && tick;
      end
      PAUSE: begin
        state_d = bus.i_stop ? IDLE : bus.i_start ? RUN : PAUSE;
        idx_d   = bus.i_stop ? '0 : idx_q;
        pre_clr = bus.i_stop;
        adv     = !bus.i_stop && !bus.i_start && bus.i_step;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        pre_clr = 1'b1;
      end
    endcase
    // One-shot completion replaces the wrap with a return to IDLE.
    if (adv && wrap && !bus.i_loop) begin
      state_d = IDLE;
      idx_d   = '0;
      pre_clr = 1'b1;
      done_d  = 1'b1;
    end else if (adv) begin
      idx_d = wrap ? (bus.i_dir ? LAST : '0) : bus.i_dir ? idx_q - 1'b1 : idx_q + 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    state_q <= i_rst ? IDLE : state_d;
    idx_q   <= i_rst ? '0 : idx_d;
    done_q  <= i_rst ? 1'b0 : done_d;
  end
  assign bus.o_led_index = idx_q;
  assign bus.o_led       = led_rom(idx_q);
  assign bus.o_busy      = state_q != IDLE;
  assign bus.o_done      = done_q;
endmodule
